// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a CPU port and a loader port share one
// memory. Round-robin on ties; each access holds its strobe for
// WAIT_CYCLES+1 cycles, then pulses ready/done for one cycle.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic [7:0]  ld_rdata,
    output logic        ld_done,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy
);

    localparam logic [2:0] WaitCnt = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;  // 1 = loader granted last
    logic        gnt_ld_q, gnt_ld_d;          // current access belongs to loader
    logic        we_q, we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        ld_done_q, ld_done_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  ld_rdata_q, ld_rdata_d;
    logic        busy_q, busy_d;

    logic cpu_req;
    logic pick_ld;
    logic nxt_we;

    assign cpu_req = cpu_read | cpu_write;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_ld_d     = gnt_ld_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        cpu_ready_d  = 1'b0;
        ld_done_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ld_rdata_d   = ld_rdata_q;
        pick_ld      = 1'b0;
        nxt_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req || ld_req) begin
                    // Loader wins only when alone or when the CPU went last
                    pick_ld      = ld_req && (!cpu_req || !last_grant_q);
                    nxt_we       = pick_ld ? ld_we : cpu_write;
                    gnt_ld_d     = pick_ld;
                    last_grant_d = pick_ld;
                    we_d         = nxt_we;
                    mem_addr_d   = pick_ld ? ld_addr : cpu_addr;
                    mem_wdata_d  = pick_ld ? ld_wdata : cpu_wdata;
                    mem_rd_d     = !nxt_we;
                    mem_wr_d     = nxt_we;
                    cnt_d        = 3'd0;
                    state_d      = StAcc;
                end
            end
            StAcc: begin
                if (cnt_q == WaitCnt) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!we_q) begin
                        if (gnt_ld_q) ld_rdata_d  = mem_rdata;
                        else          cpu_rdata_d = mem_rdata;
                    end
                    cpu_ready_d = !gnt_ld_q;
                    ld_done_d   = gnt_ld_q;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            gnt_ld_q     <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 8'h00;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            cpu_ready_q  <= 1'b0;
            ld_done_q    <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            ld_rdata_q   <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_ld_q     <= gnt_ld_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            cpu_ready_q  <= cpu_ready_d;
            ld_done_q    <= ld_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign ld_rdata  = ld_rdata_q;
    assign ld_done   = ld_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=0 share all inputs. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ld_req, ld_we;
    logic [15:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  cpu_rdata, ld_rdata, mem_wdata;
    logic        cpu_ready, ld_done, mem_rd, mem_wr, busy;
    logic [15:0] mem_addr;

    logic [7:0]  cpu_rdata0, ld_rdata0, mem_wdata0;
    logic        cpu_ready0, ld_done0, mem_rd0, mem_wr0, busy0;
    logic [15:0] mem_addr0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_done(ld_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .cpu_ready(cpu_ready0),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata0), .ld_done(ld_done0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .busy(busy0)
    );

    task automatic do_reset();
        cpu_read  = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        ld_req    = 1'b0; ld_we     = 1'b0; ld_addr  = 16'h0; ld_wdata  = 8'h0;
        mem_rdata = 8'h0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({mem_rd, mem_wr, cpu_ready, ld_done, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 00000",
                     {mem_rd, mem_wr, cpu_ready, ld_done, busy});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, cpu_rdata, ld_rdata} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {mem_addr, mem_wdata, cpu_rdata, ld_rdata});
        end
        n_cmp++;
        if ({mem_rd0, mem_wr0, cpu_ready0, ld_done0, busy0} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl_w0: got %b expected 00000",
                     {mem_rd0, mem_wr0, cpu_ready0, ld_done0, busy0});
        end
    endtask

    // CPU read, WAIT_CYCLES=1: strobe 2 cycles, ready in cycle 3
    task automatic test_cpu_read();
        int rd_cnt = 0, rdy_cnt = 0, rdy_k = -1, both = 0;
        do_reset();
        cpu_read = 1'b1; cpu_addr = 16'h0012; mem_rdata = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_rd && mem_wr) both++;
            if (k == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rd_busy: got %b expected 1", busy);
                end
            end
            if (mem_rd) begin
                rd_cnt++;
                n_cmp++;
                if (mem_addr !== 16'h0012) begin
                    n_fail++;
                    $display("FAIL rd_addr: got %h expected 0012", mem_addr);
                end
            end
            if (cpu_ready) begin
                rdy_cnt++;
                if (rdy_k < 0) rdy_k = k;
                n_cmp++;
                if (cpu_rdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected a5", cpu_rdata);
                end
                cpu_read = 1'b0;
            end
        end
        n_cmp++;
        if (rd_cnt !== 2) begin
            n_fail++; $display("FAIL rd_strobe_len: got %0d expected 2", rd_cnt);
        end
        n_cmp++;
        if (rdy_k !== 3) begin
            n_fail++; $display("FAIL rd_latency: got %0d expected 3", rdy_k);
        end
        n_cmp++;
        if (rdy_cnt !== 1) begin
            n_fail++; $display("FAIL rd_ready_cnt: got %0d expected 1", rdy_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0 || cpu_rdata !== 8'hA5 || both !== 0) begin
            n_fail++;
            $display("FAIL rd_after: got busy=%b rdata=%h both=%0d expected 0/a5/0",
                     busy, cpu_rdata, both);
        end
    endtask

    // Simultaneous CPU write and loader read after reset: CPU first
    task automatic test_tie();
        int rdy_k = -1, done_k = -1, early_done = 0, wr_cnt = 0, rd_cnt = 0;
        do_reset();
        cpu_write = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h11;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0300; mem_rdata = 8'h5A;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_wr) begin
                wr_cnt++;
                n_cmp++;
                if (mem_addr !== 16'h0200 || mem_wdata !== 8'h11) begin
                    n_fail++;
                    $display("FAIL tie_wr_bus: got %h/%h expected 0200/11",
                             mem_addr, mem_wdata);
                end
            end
            if (mem_rd) begin
                rd_cnt++;
                n_cmp++;
                if (mem_addr !== 16'h0300) begin
                    n_fail++;
                    $display("FAIL tie_rd_addr: got %h expected 0300", mem_addr);
                end
            end
            if (cpu_ready) begin
                rdy_k = k;
                cpu_write = 1'b0;
            end
            if (ld_done) begin
                if (rdy_k < 0) early_done++;
                done_k = k;
                n_cmp++;
                if (ld_rdata !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL tie_ld_data: got %h expected 5a", ld_rdata);
                end
                ld_req = 1'b0;
            end
        end
        n_cmp++;
        if (rdy_k !== 3 || early_done !== 0) begin
            n_fail++;
            $display("FAIL tie_cpu_first: got ready_k=%0d early=%0d expected 3/0",
                     rdy_k, early_done);
        end
        n_cmp++;
        if (done_k - rdy_k !== 4) begin
            n_fail++;
            $display("FAIL tie_ld_gap: got %0d expected 4", done_k - rdy_k);
        end
        n_cmp++;
        if (wr_cnt !== 2 || rd_cnt !== 2) begin
            n_fail++;
            $display("FAIL tie_strobes: got wr=%0d rd=%0d expected 2/2", wr_cnt, rd_cnt);
        end
        n_cmp++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL tie_cpu_rdata_hold: got %h expected 00", cpu_rdata);
        end
    endtask

    // Both held for four accesses: C, L, C, L
    task automatic test_round_robin();
        logic [3:0] order = 4'b0;  // bit i = 1 if access i went to loader
        int n = 0, last_k = -1, both = 0;
        do_reset();
        cpu_read = 1'b1; cpu_addr = 16'h0400; mem_rdata = 8'h77;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0500; ld_wdata = 8'h42;
        for (int k = 1; k <= 40 && n < 4; k++) begin
            @(negedge clk);
            if (mem_rd && mem_wr) both++;
            if (cpu_ready && n < 4) begin order[n] = 1'b0; n++; last_k = k; end
            if (ld_done && n < 4) begin order[n] = 1'b1; n++; last_k = k; end
        end
        cpu_read = 1'b0; ld_req = 1'b0;
        n_cmp++;
        if (n !== 4) begin
            n_fail++; $display("FAIL rr_count: got %0d expected 4", n);
        end
        n_cmp++;
        if (order !== 4'b1010) begin
            n_fail++; $display("FAIL rr_order: got %b expected 1010", order);
        end
        n_cmp++;
        if (last_k !== 15) begin
            n_fail++; $display("FAIL rr_timing: got %0d expected 15", last_k);
        end
        n_cmp++;
        if (cpu_rdata !== 8'h77 || ld_rdata !== 8'h00 || both !== 0) begin
            n_fail++;
            $display("FAIL rr_data: got %h/%h both=%0d expected 77/00/0",
                     cpu_rdata, ld_rdata, both);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // cpu_read and cpu_write together resolve to a write
    task automatic test_both_rw();
        int rd_cnt = 0, wr_cnt = 0, rdy_cnt = 0;
        do_reset();
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h3C;
        mem_rdata = 8'hEE;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_rd) rd_cnt++;
            if (mem_wr) begin
                wr_cnt++;
                n_cmp++;
                if (mem_wdata !== 8'h3C || mem_addr !== 16'h0100) begin
                    n_fail++;
                    $display("FAIL rw_bus: got %h/%h expected 0100/3c", mem_addr, mem_wdata);
                end
            end
            if (cpu_ready) begin
                rdy_cnt++;
                cpu_read = 1'b0; cpu_write = 1'b0;
            end
        end
        n_cmp++;
        if (rd_cnt !== 0 || wr_cnt !== 2 || rdy_cnt !== 1) begin
            n_fail++;
            $display("FAIL rw_strobes: got rd=%0d wr=%0d rdy=%0d expected 0/2/1",
                     rd_cnt, wr_cnt, rdy_cnt);
        end
        n_cmp++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++; $display("FAIL rw_rdata_hold: got %h expected 00", cpu_rdata);
        end
    endtask

    // Reset in the middle of a loader write aborts it silently
    task automatic test_reset_mid_acc();
        int done_cnt = 0;
        do_reset();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0600; ld_wdata = 8'h99;
        @(negedge clk);
        n_cmp++;
        if (mem_wr !== 1'b1 || mem_addr !== 16'h0600) begin
            n_fail++;
            $display("FAIL abort_pre: got wr=%b addr=%h expected 1/0600", mem_wr, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ld_req = 1'b0;
        n_cmp++;
        if ({mem_wr, mem_rd, busy, ld_done} !== 4'b0 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_state: got %b addr=%h expected 0000/0000",
                     {mem_wr, mem_rd, busy, ld_done}, mem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ld_done) done_cnt++;
        end
        n_cmp++;
        if (done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt);
        end
    endtask

    // WAIT_CYCLES=0 loader read; the WAIT_CYCLES=1 instance also sees the
    // request drop mid-access and must still finish it
    task automatic test_wait0();
        int rd_cnt = 0, done_k = -1, done1_k = -1;
        do_reset();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'hFFFF; mem_rdata = 8'hC3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_rd0) begin
                rd_cnt++;
                n_cmp++;
                if (mem_addr0 !== 16'hFFFF) begin
                    n_fail++; $display("FAIL w0_addr: got %h expected ffff", mem_addr0);
                end
            end
            if (ld_done0) begin
                if (done_k < 0) done_k = k;
                n_cmp++;
                if (ld_rdata0 !== 8'hC3) begin
                    n_fail++; $display("FAIL w0_data: got %h expected c3", ld_rdata0);
                end
                ld_req = 1'b0;
            end
            if (ld_done && done1_k < 0) done1_k = k;
        end
        n_cmp++;
        if (rd_cnt !== 1) begin
            n_fail++; $display("FAIL w0_strobe_len: got %0d expected 1", rd_cnt);
        end
        n_cmp++;
        if (done_k !== 2) begin
            n_fail++; $display("FAIL w0_latency: got %0d expected 2", done_k);
        end
        n_cmp++;
        if (done1_k !== 3 || ld_rdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL drop_mid_acc: got k=%0d data=%h expected 3/c3", done1_k, ld_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_tie();
        test_round_robin();
        test_both_rw();
        test_reset_mid_acc();
        test_wait0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, setting the number of extra cycles a memory strobe is held beyond the first (legal range 0..7).
REQ-002 The block SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_read  in  1  CPU read request, level, held until cpu_ready.
- cpu_write  in  1  CPU write request, level, held until cpu_ready.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- ld_req  in  1  loader request, level, held until ld_done.
- ld_we  in  1  loader direction: 1=write, 0=read.
- ld_addr  in  16  loader address.
- ld_wdata  in  8  loader write data.
- ld_rdata  out  8  loader read data, valid while ld_done=1.
- ld_done  out  1  one-cycle completion pulse to loader.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- busy  out  1  high in any state other than IDLE.
REQ-003 The block SHALL have exactly one clock, clk, and reset rst, synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ACC, RESP; all outputs SHALL be registered.
REQ-005 CPU request SHALL be cpu_read|cpu_write; if both are high, the access SHALL be a write.
REQ-006 In IDLE with exactly one requester active, that requester SHALL be granted at the next edge.
REQ-007 In IDLE with both active, the requester not granted last SHALL win (round-robin); last_grant SHALL update on every grant.
REQ-008 On grant: address, write data and direction SHALL be latched; mem_addr/mem_wdata SHALL take the latched values; exactly one of mem_rd/mem_wr SHALL go high; wait counter SHALL clear to 0; state->ACC.
REQ-009 In ACC the counter SHALL increment each edge; at the edge where counter==WAIT_CYCLES, strobes SHALL drop, mem_rdata SHALL be captured (reads only), state->RESP.
REQ-010 Strobe SHALL therefore be high for exactly WAIT_CYCLES+1 cycles; mem_addr/mem_wdata SHALL be stable throughout.
REQ-011 In RESP, the granted requester's ready/done SHALL be high for exactly one cycle with captured read data on its rdata; state->IDLE at next edge.
REQ-012 Latency from request sampled in IDLE to ready/done SHALL be WAIT_CYCLES+2 cycles; a new grant SHALL be possible in the cycle after RESP.
REQ-013 Requester inputs changing or dropping during ACC SHALL NOT affect the access in progress; the RESP pulse SHALL still be issued.
REQ-014 Non-granted requester's ready/done SHALL stay 0; its rdata SHALL hold its last value.
REQ-015 mem_rd and mem_wr SHALL never be high simultaneously; outside ACC both SHALL be 0.
REQ-016 Write accesses SHALL leave cpu_rdata/ld_rdata unchanged.

Reset
REQ-017 On rst=1 at an edge, from any state including mid-ACC: state=IDLE, mem_rd=mem_wr=0, cpu_ready=ld_done=0, busy=0, mem_addr=0, mem_wdata=0, cpu_rdata=ld_rdata=0, counter=0, last_grant=loader (CPU wins the first tie).
REQ-018 An access aborted by reset SHALL produce no ready/done pulse.

Verification
REQ-019 WAIT_CYCLES=1, cpu_read, addr 0x0012, mem_rdata=0xA5 -> mem_rd high 2 cycles with mem_addr=0x0012, cpu_ready pulse 3 cycles after request, cpu_rdata=0xA5.
REQ-020 After reset, cpu_write and ld_req both asserted same cycle -> CPU granted first, loader granted in the cycle after CPU RESP; ld_done 4 cycles after cpu_ready.
REQ-021 Both requesters held continuously for 4 accesses -> grants alternate CPU, LD, CPU, LD.
REQ-022 cpu_read=cpu_write=1, addr 0x0100, wdata 0x3C -> mem_wr only, mem_wdata=0x3C, mem_rd stays 0.
REQ-023 rst asserted during ACC of a loader write -> next cycle mem_wr=0, busy=0, no ld_done pulse.
REQ-024 WAIT_CYCLES=0, ld read of 0xFFFF -> mem_rd high exactly 1 cycle, ld_done 2 cycles after request.
